// File: rtl/uc_multiciclo_if.sv
// Control bundle between the multi-cycle control unit and its datapath.
// The slave side is the control unit; the master side drives opcode and mem_ready.
interface uc_multiciclo_if #(
  parameter int unsigned STATE_W = 4
);
  localparam int unsigned OP_W = 6;

  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               BranchNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         MemtoReg;
  logic [1:0]         RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );

  modport slave (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multi-cycle MIPS-subset control unit: sequences fetch/decode/execute/memory/writeback
// with a memory ready handshake, optional link-on-jump and illegal-opcode trapping.
module uc_multiciclo #(
  parameter bit          JAL_ON_J     = 1'b1,
  parameter bit          TRAP_ILLEGAL = 1'b1,
  parameter int unsigned STATE_W      = 4
) (
  input  logic           clk,
  input  logic           reset,
  uc_multiciclo_if.slave bus
);
  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

  // Opcode is captured in DECODE so later steps do not rely on the IR staying put.
  assign op_d = (state_q == S_DECODE) ? bus.opcode : op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign bus.state = STATE_W'(state_q);

  // Next-state and control decode of the current state.
  always_comb begin
    state_d         = S_FETCH;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 2'b00;
    bus.RegDst      = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = S_EXEC;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default:          state_d = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_d      = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = S_RWB;
      end
      S_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b01;
      end
      S_IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
        state_d     = S_IWB;
      end
      S_IWB: begin
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.BranchNe    = (op_q == OP_BNE);
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        if (JAL_ON_J) begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'b10;
          bus.MemtoReg = 2'b10;
        end
      end
      S_ILLEGAL: begin
        bus.illegal_op = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomised bench for uc_multiciclo: an instruction-level model expands each opcode into
// its expected per-cycle state/control trace, checked on two parameterisations.
module tb_uc_multiciclo;
  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw;
    logic [1:0] m2r, rdst;
    logic       rw, asa;
    logic [1:0] asb, aop, pcs;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    ctl_t       c;
  } rec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  rec_t q[$];

  uc_multiciclo_if #(.STATE_W(4)) bus_a ();
  uc_multiciclo_if #(.STATE_W(4)) bus_b ();

  uc_multiciclo #(.JAL_ON_J(1'b1), .TRAP_ILLEGAL(1'b1), .STATE_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  uc_multiciclo #(.JAL_ON_J(1'b0), .TRAP_ILLEGAL(1'b0), .STATE_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  ctl_t obs_a, obs_b;
  assign obs_a = {bus_a.PCWrite, bus_a.PCWriteCond, bus_a.BranchNe, bus_a.IorD, bus_a.MemRead,
                  bus_a.MemWrite, bus_a.IRWrite, bus_a.MemtoReg, bus_a.RegDst, bus_a.RegWrite,
                  bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ALUOp, bus_a.PCSource, bus_a.illegal_op};
  assign obs_b = {bus_b.PCWrite, bus_b.PCWriteCond, bus_b.BranchNe, bus_b.IorD, bus_b.MemRead,
                  bus_b.MemWrite, bus_b.IRWrite, bus_b.MemtoReg, bus_b.RegDst, bus_b.RegWrite,
                  bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ALUOp, bus_b.PCSource, bus_b.illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push(input logic [5:0] op, input logic mr, input logic [3:0] st, input ctl_t c);
    rec_t r;
    r.op = op; r.mr = mr; r.st = st; r.c = c;
    q.push_back(r);
  endtask

  // Expand one instruction into its cycle trace; fw/mw are wait cycles on fetch / data access.
  task automatic build(input logic [5:0] op, input int fw, input int mw, input bit jal, input bit trap);
    ctl_t c;
    c = '0; c.mrd = 1'b1; c.asb = 2'b01;
    for (int i = 0; i < fw; i++) push(6'($urandom), 1'b0, 4'd0, c);
    c.irw = 1'b1; c.pcw = 1'b1;
    push(6'($urandom), 1'b1, 4'd0, c);
    c = '0; c.asb = 2'b11;
    push(op, 1'($urandom), 4'd1, c);
    case (op)
      6'b100011, 6'b101011: begin
        c = '0; c.asa = 1'b1; c.asb = 2'b10;
        push(6'($urandom), 1'($urandom), 4'd2, c);
        c = '0; c.iord = 1'b1;
        if (op == 6'b100011) c.mrd = 1'b1; else c.mwr = 1'b1;
        for (int i = 0; i < mw; i++) push(6'($urandom), 1'b0, (op == 6'b100011) ? 4'd3 : 4'd5, c);
        push(6'($urandom), 1'b1, (op == 6'b100011) ? 4'd3 : 4'd5, c);
        if (op == 6'b100011) begin
          c = '0; c.rw = 1'b1; c.m2r = 2'b01;
          push(6'($urandom), 1'($urandom), 4'd4, c);
        end
      end
      6'b000000: begin
        c = '0; c.asa = 1'b1; c.aop = 2'b10;
        push(6'($urandom), 1'($urandom), 4'd6, c);
        c = '0; c.rw = 1'b1; c.rdst = 2'b01;
        push(6'($urandom), 1'($urandom), 4'd7, c);
      end
      6'b001000, 6'b001100: begin
        c = '0; c.asa = 1'b1; c.asb = 2'b10; c.aop = (op == 6'b001100) ? 2'b11 : 2'b00;
        push(6'($urandom), 1'($urandom), 4'd10, c);
        c = '0; c.rw = 1'b1;
        push(6'($urandom), 1'($urandom), 4'd11, c);
      end
      6'b000100, 6'b000101: begin
        c = '0; c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01;
        c.bne = (op == 6'b000101);
        push(6'($urandom), 1'($urandom), 4'd8, c);
      end
      6'b000010: begin
        c = '0; c.pcw = 1'b1; c.pcs = 2'b10;
        if (jal) begin c.rw = 1'b1; c.rdst = 2'b10; c.m2r = 2'b10; end
        push(6'($urandom), 1'($urandom), 4'd9, c);
      end
      default: begin
        if (trap) begin
          c = '0; c.ill = 1'b1;
          push(6'($urandom), 1'($urandom), 4'd12, c);
        end
      end
    endcase
  endtask

  // Replay up to n queued cycles on the selected DUT; entered and left at posedge+1.
  task automatic run_q(input bit which, input int n);
    rec_t r;
    int   k;
    k = 0;
    while (q.size() > 0 && k < n) begin
      r = q.pop_front();
      if (which) begin bus_b.opcode = r.op; bus_b.mem_ready = r.mr; end
      else       begin bus_a.opcode = r.op; bus_a.mem_ready = r.mr; end
      @(negedge clk);
      check(which ? "b_state" : "a_state", 32'(which ? bus_b.state : bus_a.state), 32'(r.st));
      check(which ? "b_ctrl" : "a_ctrl", 32'(which ? obs_b : obs_a), 32'(r.c));
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic instr(input bit which, input logic [5:0] op, input int fw, input int mw);
    build(op, fw, mw, !which, !which);
    run_q(which, 1000);
  endtask

  logic [5:0] ops [10];
  ctl_t       fetch_idle;

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1;
    bus_a.opcode = '0; bus_a.mem_ready = 1'b0;
    bus_b.opcode = '0; bus_b.mem_ready = 1'b0;
    ops = '{6'b000000, 6'b001000, 6'b001100, 6'b100011, 6'b101011,
            6'b000100, 6'b000101, 6'b000010, 6'b111111, 6'b010001};
    fetch_idle = '0; fetch_idle.mrd = 1'b1; fetch_idle.asb = 2'b01;
    @(posedge clk); #1;
    do_reset();

    @(negedge clk);
    check("rst_state", 32'(bus_a.state), 32'd0);
    check("rst_ctrl", 32'(obs_a), 32'(fetch_idle));
    @(posedge clk); #1;

    instr(1'b0, 6'b000000, 0, 0);
    instr(1'b0, 6'b100011, 0, 2);
    instr(1'b0, 6'b101011, 0, 0);
    instr(1'b0, 6'b000101, 0, 0);
    instr(1'b0, 6'b000100, 0, 0);
    instr(1'b0, 6'b000010, 0, 0);
    instr(1'b0, 6'b111111, 0, 0);
    instr(1'b0, 6'b001100, 1, 0);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) instr(1'b0, 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else instr(1'b0, ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset taken while a store is stalled in MEMWR.
    build(6'b101011, 0, 3, 1'b1, 1'b1);
    run_q(1'b0, 3);
    q.delete();
    bus_a.mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("memwr_state", 32'(bus_a.state), 32'd5);
    check("memwr_we", 32'(bus_a.MemWrite), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mw_state", 32'(bus_a.state), 32'd0);
    check("rst_mw_we", 32'(bus_a.MemWrite), 32'd0);
    check("rst_mw_ctrl", 32'(obs_a), 32'(fetch_idle));
    @(posedge clk); #1;

    do_reset();
    instr(1'b1, 6'b000010, 0, 0);
    instr(1'b1, 6'b111111, 0, 0);
    instr(1'b1, 6'b100011, 2, 1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) instr(1'b1, 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else instr(1'b1, ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multi-cycle successor to the single-cycle control unit. Registered FSM that sequences the fetch, decode, execute, memory and writeback steps of a MIPS-subset datapath with one shared memory.
- Decodes the same opcodes as the single-cycle unit: R-format, ADDI, ANDI, LW, SW, BEQ, BNE, J.
- Adds three things the single-cycle unit lacks: a memory ready handshake, an optional link-on-jump mode, and illegal-opcode trapping.

Parameters:
- JAL_ON_J, 1: when 1, J also writes PC+4 into register 31. When 0, J does not write the register file.
- TRAP_ILLEGAL, 1: when 1, an undefined opcode goes to the ILLEGAL state. When 0, it returns to FETCH silently.
- STATE_W, 4: width of the state register and of the state output.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26], taken from the instruction register
- mem_ready  in  1  memory completed the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by the branch condition
- BranchNe  out  1  0 = take branch on zero (BEQ), 1 = take branch on not-zero (BNE)
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
- RegDst  out  2  write-register select: 00 = rt, 01 = rd, 10 = register 31
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field, 11 = and
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- state  out  STATE_W  current state, for debug

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a rising edge with reset=1, state <= FETCH. Reset wins over any transition, including mid-instruction; an in-progress memory write is abandoned.
- Outputs are combinational decodes of the state register, plus mem_ready where noted. Any signal not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, ILLEGAL=12.
- After reset, every output equals the FETCH decode: MemRead=1, ALUSrcB=01, all others 0, state=0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Next state: DECODE if mem_ready, otherwise stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes the branch target).
  - Next state by opcode: LW/SW -> MEMADR; R-format -> EXEC; ADDI/ANDI -> IEXEC; BEQ/BNE -> BRANCH; J -> JUMP.
  - Any other opcode -> ILLEGAL if TRAP_ILLEGAL=1, otherwise FETCH.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMRD for LW, MEMWR for SW.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Next state: MEMWB if mem_ready, otherwise hold.
- MEMWB:
  - Outputs: RegWrite=1, RegDst=00, MemtoReg=01.
  - Next state: FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Next state: FETCH if mem_ready, otherwise hold. MemWrite stays high for every wait cycle.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: RWB.
- RWB:
  - Outputs: RegWrite=1, RegDst=01, MemtoReg=00.
  - Next state: FETCH.
- IEXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=10; ALUOp=00 for ADDI, 11 for ANDI.
  - Next state: IWB.
  - The opcode is latched at DECODE into an internal register, so IEXEC does not depend on opcode staying stable.
- IWB:
  - Outputs: RegWrite=1, RegDst=00, MemtoReg=00.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; BranchNe=1 for BNE, 0 for BEQ.
  - Next state: FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=10.
  - If JAL_ON_J=1, also RegWrite=1, RegDst=10, MemtoReg=10.
  - Next state: FETCH.
- ILLEGAL:
  - Outputs: illegal_op=1 for this single cycle.
  - Next state: FETCH. The PC is not rewritten.
- Latency with zero wait (mem_ready held at 1):
  - LW 5 cycles; R-format, ADDI, ANDI, SW 4 cycles; BEQ, BNE, J 3 cycles; illegal 3 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Unreachable state codes (13-15) decode to all-zero outputs and go to FETCH on the next cycle.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 -> state sequence 0,1,6,7,0. RegWrite=1 and RegDst=01 only in state 7. IRWrite pulses in cycle 1.
- LW (100011) with mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 held through the waits. MemtoReg=01 in state 4.
- SW (101011) with mem_ready=1 -> sequence 0,1,2,5,0. MemWrite=1 only in state 5. RegWrite never asserted.
- BNE (000101), then BEQ (000100) -> each visits BRANCH (8) with PCWriteCond=1 and ALUOp=01. BranchNe=1 for BNE, 0 for BEQ.
- J (000010): with JAL_ON_J=1 -> state 9 shows PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. With JAL_ON_J=0 -> RegWrite=0.
- Opcode 111111 -> state 12 with a one-cycle illegal_op pulse, then FETCH. Separately, assert reset while in MEMWR with mem_ready=0 -> next state 0 and MemWrite drops immediately.
